// File: rtl/mult_acc_pkg.sv
// ---------------------------------------------------------------------------
// mult_acc_pkg
// Shared definitions for the multiply-accumulate block: the control FSM state
// encoding, the width of the term counter and the default accumulator width.
// No ports; imported by mult_accumulator.
// ---------------------------------------------------------------------------
package mult_acc_pkg;

  // Term counter width; the counter saturates at its all-ones value.
  localparam int COUNT_W = 8;

  // Default accumulator / result width in bits.
  localparam int ACC_W_DEFAULT = 12;

  // IDLE  : nothing pending
  // ACCUM : part of a group has been accepted
  // DRAIN : the last term of the group sits in the operand register
  // HOLD  : result is offered on the output side
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_accumulator_csm.sv
// ---------------------------------------------------------------------------
// carry_save_multiplier
// Purely combinational 4x4 unsigned multiplier. Partial-product rows are
// folded into a redundant sum/carry pair with 3:2 compressors, and a single
// carry-propagate add at the end resolves the 8-bit product.
// Ports:
//   a_i  [3:0]  multiplicand
//   b_i  [3:0]  multiplier
//   p_o  [7:0]  a_i * b_i
// ---------------------------------------------------------------------------
module carry_save_multiplier (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] sumVec;
  logic [7:0] carryVec;
  logic [7:0] row;
  logic [7:0] sumNext;
  logic [7:0] carryNext;

  // Compress each shifted partial-product row into the running sum/carry
  // pair. Bits carried past bit 7 can be dropped because the true product
  // never exceeds 225, so the pair stays correct modulo 256.
  always_comb begin
    sumVec    = '0;
    carryVec  = '0;
    row       = '0;
    sumNext   = '0;
    carryNext = '0;
    for (int i = 0; i < 4; i++) begin
      row       = {4'b0000, a_i & {4{b_i[i]}}} << i;
      sumNext   = sumVec ^ carryVec ^ row;
      carryNext = ((sumVec & carryVec) | (sumVec & row) | (carryVec & row)) << 1;
      sumVec    = sumNext;
      carryVec  = carryNext;
    end
  end

  // Final carry-propagate stage.
  assign p_o = sumVec + carryVec;

endmodule

// File: rtl/mult_accumulator.sv
// ---------------------------------------------------------------------------
// mult_accumulator
// Accumulates a*b products over a group of terms terminated by in_last and
// offers the group sum, term count and a sticky overflow flag through a
// valid/ready output. One operand register stage (P1) feeds the multiplier;
// the accumulator updates one edge after each accepted term.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/ready operand handshake; in_ready depends only on state
//   in_a, in_b     4-bit unsigned operands
//   in_last        final term of the current group
//   out_valid/ready result handshake
//   out_sum        group sum modulo 2^ACC_W
//   out_count      terms in group, saturating at 255
//   out_overflow   any accumulation in the group carried out of ACC_W bits
// ---------------------------------------------------------------------------
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_a,
  input  logic [3:0]         in_b,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_overflow
);

  state_e state_q, state_d;

  logic       p1Valid_q;
  logic [3:0] p1A_q;
  logic [3:0] p1B_q;
  logic       p1Last_q;

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               outValid_q, outValid_d;
  logic [ACC_W-1:0]   outSum_q, outSum_d;
  logic [COUNT_W-1:0] outCount_q, outCount_d;
  logic               outOvf_q, outOvf_d;

  logic               transfer;
  logic [7:0]         product;
  logic [ACC_W:0]     sumExt;
  logic [ACC_W-1:0]   accNext;
  logic [COUNT_W-1:0] countNext;
  logic               ovfNext;

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign transfer = in_valid && in_ready;

  carry_save_multiplier uMult (
    .a_i (p1A_q),
    .b_i (p1B_q),
    .p_o (product)
  );

  // One extra bit on the adder exposes the carry-out that feeds the sticky
  // overflow flag; the stored sum simply drops it.
  assign sumExt    = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, product};
  assign accNext   = sumExt[ACC_W-1:0];
  assign ovfNext   = ovf_q | sumExt[ACC_W];
  assign countNext = (count_q == '1) ? count_q : count_q + 1'b1;

  // Control FSM next state. DRAIN exists only to give the last term its
  // cycle in P1, so the output side goes valid exactly one edge later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (transfer) begin
          state_d = in_last ? DRAIN : ACCUM;
        end
      end
      DRAIN: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (outValid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Accumulator and output-register next state. A last term publishes the
  // updated totals and clears the running group in the same edge.
  always_comb begin
    acc_d      = acc_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    outValid_d = outValid_q;
    outSum_d   = outSum_q;
    outCount_d = outCount_q;
    outOvf_d   = outOvf_q;
    if (p1Valid_q) begin
      if (p1Last_q) begin
        outSum_d   = accNext;
        outCount_d = countNext;
        outOvf_d   = ovfNext;
        outValid_d = 1'b1;
        acc_d      = '0;
        count_d    = '0;
        ovf_d      = 1'b0;
      end else begin
        acc_d   = accNext;
        count_d = countNext;
        ovf_d   = ovfNext;
      end
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // P1 operand stage: the valid bit reflects only this edge's transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1Valid_q <= 1'b0;
      p1A_q     <= '0;
      p1B_q     <= '0;
      p1Last_q  <= 1'b0;
    end else begin
      p1Valid_q <= transfer;
      if (transfer) begin
        p1A_q    <= in_a;
        p1B_q    <= in_b;
        p1Last_q <= in_last;
      end
    end
  end

  // Accumulator and held-result registers; reset discards everything,
  // including a result that was waiting for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
      outSum_q   <= '0;
      outCount_q <= '0;
      outOvf_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
      outSum_q   <= outSum_d;
      outCount_q <= outCount_d;
      outOvf_q   <= outOvf_d;
    end
  end

  assign out_valid    = outValid_q;
  assign out_sum      = outSum_q;
  assign out_count    = outCount_q;
  assign out_overflow = outOvf_q;

endmodule
